jrc_phase_decoder: RTL and testbench
====================================

JRC_PHASE_DECODER -- requirements
Module: jrc_phase_decoder

Interface
REQ-001 The block SHALL have one parameter, REV_W, default 8, giving the width of the revolution counter.
REQ-002 clk  input  1  Single clock; all state SHALL update on the rising edge.
REQ-003 clr  input  1  Synchronous active-high reset.
REQ-004 qa, qb, qc, qd  input  1 each  Johnson counter state bits from the upstream 4-bit twisted-ring counter; code = {qa,qb,qc,qd}.
REQ-005 en  input  1  Sample enable; the code is evaluated only when en=1.
REQ-006 fault_clr  input  1  Clears the sticky fault flag.
REQ-007 phase  output  8  Registered one-hot decoded phase.
REQ-008 phase_idx  output  3  Registered binary phase index.
REQ-009 valid  output  1  The last sampled code was legal.
REQ-010 illegal  output  1  One-cycle pulse on an illegal code.
REQ-011 seq_err  output  1  One-cycle pulse on an out-of-order legal code.
REQ-012 fault  output  1  Sticky error flag.
REQ-013 rev_cnt  output  REV_W  Completed-revolution count.
REQ-014 rev_tick  output  1  One-cycle pulse on each completed revolution.

Function
REQ-015 Legal codes SHALL map to phases as follows: 0000->0, 1000->1, 1100->2, 1110->3, 1111->4, 0111->5, 0011->6, 0001->7; the other 8 codes are illegal.
REQ-016 All outputs SHALL be registered, with 1-cycle latency from the en=1 sample edge.
REQ-017 A legal sample SHALL give valid=1, phase_idx=index, and phase=1<<index.
REQ-018 An illegal sample SHALL give valid=0, phase=0, illegal=1, fault=1 and FSM->S_IDLE, and SHALL hold phase_idx.
REQ-019 FSM S_IDLE SHALL behave as follows: a legal sample stores the reference phase and moves to S_LOCK, with no sequence check.
REQ-020 FSM S_LOCK SHALL behave as follows:
- A legal sample equal to the reference is a hold, with no error.
- A legal sample equal to reference+1 mod 8 is an advance.
- Any other legal sample gives seq_err=1 and fault=1, stays in S_LOCK, and becomes the new reference.
REQ-021 An advance from phase 7 to phase 0 in S_LOCK SHALL increment rev_cnt modulo 2^REV_W and pulse rev_tick; a wrap from all-ones to 0 SHALL also pulse rev_tick.
REQ-022 The first sample after S_IDLE SHALL never count a revolution, even if it is phase 0.
REQ-023 With en=0, phase, phase_idx, valid, rev_cnt, fault and the FSM SHALL hold, and illegal, seq_err and rev_tick SHALL be 0.
REQ-024 fault_clr=1 SHALL clear fault next cycle; if an error is detected in the same cycle, fault SHALL be 1 (error wins).
REQ-025 The pulse outputs SHALL each be high for exactly one cycle per event.

Reset
REQ-026 With clr=1 at a clk edge, the outputs SHALL be: phase=0, phase_idx=0, valid=0, illegal=0, seq_err=0, fault=0, rev_cnt=0, rev_tick=0.
REQ-027 With clr=1 at a clk edge, the FSM SHALL go to S_IDLE and the reference phase SHALL be 0.
REQ-028 clr SHALL take priority over en and fault_clr, including mid-revolution; the next legal sample after release re-locks per REQ-019.

Configuration
REQ-029 Macro JRC_PHASE_DECODER_SEQCHK_EN SHALL control sequence checking.
- When defined, REQ-020 sequence checking is included.
- When undefined, seq_err SHALL be constant 0, out-of-order legal codes SHALL only update the reference, and fault SHALL be set by illegal codes only.
- rev_cnt and rev_tick behaviour SHALL be identical in both builds.

Verification
REQ-030 Reset then en=1 with the full legal sequence 0000,1000,...,0001,0000 -> phase_idx 0..7,0; valid=1 throughout; rev_tick once; rev_cnt=1; seq_err=0.
REQ-031 Locked on 1100, then sample 1111 -> seq_err=1 for one cycle, fault=1, phase_idx=4; with the macro undefined -> seq_err=0, fault=0.
REQ-032 Sample 1010 -> illegal=1, valid=0, phase=0, fault=1; next 0000 re-locks without rev_tick.
REQ-033 Run 256 revolutions with REV_W=8 -> rev_cnt wraps to 0 with rev_tick=1 on the wrap.
REQ-034 Illegal code and fault_clr in the same cycle -> fault stays 1; fault_clr alone -> fault=0 next cycle.
REQ-035 clr asserted at phase 5 with en=1 -> all outputs 0 next cycle; then 0110 sampled -> illegal=1, and 0000 after that -> no rev_tick.

Source files
------------

// File: rtl/jrc_phase_decoder.sv
// jrc_phase_decoder: Johnson-code phase decoder with order check and revolution counter; JRC_PHASE_DECODER_SEQCHK_EN enables sequence checking.
module jrc_phase_decoder #(
  parameter int REV_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             qa,
  input  logic             qb,
  input  logic             qc,
  input  logic             qd,
  input  logic             en,
  input  logic             fault_clr,
  output logic [7:0]       phase,
  output logic [2:0]       phase_idx,
  output logic             valid,
  output logic             illegal,
  output logic             seq_err,
  output logic             fault,
  output logic [REV_W-1:0] rev_cnt,
  output logic             rev_tick
);
`ifdef JRC_PHASE_DECODER_SEQCHK_EN
  localparam logic SEQ = 1'b1;
`else
  localparam logic SEQ = 1'b0;
`endif
  typedef enum logic {S_IDLE, S_LOCK} state_t;
  state_t state_q, state_d;
  logic [2:0] ref_q, ref_d, idx_q, idx_d, idx;
  logic [7:0] phase_q, phase_d;
  logic [REV_W-1:0] rev_q, rev_d;
  logic valid_q, valid_d, illegal_q, illegal_d, seq_err_q, seq_err_d;
  logic fault_q, fault_d, tick_q, tick_d, legal, err;
  always_comb begin
    legal = 1'b1;
    idx = 3'd0;
    case ({qa, qb, qc, qd})
      4'b0000: idx = 3'd0;
      4'b1000: idx = 3'd1;
      4'b1100: idx = 3'd2;
      4'b1110: idx = 3'd3;
      4'b1111: idx = 3'd4;
      4'b0111: idx = 3'd5;
      4'b0011: idx = 3'd6;
      4'b0001: idx = 3'd7;
      default: legal = 1'b0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    ref_d = ref_q;
    phase_d = phase_q;
    idx_d = idx_q;
    valid_d = valid_q;
    rev_d = rev_q;
    illegal_d = 1'b0;
    seq_err_d = 1'b0;
    tick_d = 1'b0;
    err = 1'b0;
    if (en && !legal) begin
      valid_d = 1'b0;
      phase_d = 8'd0;
      illegal_d = 1'b1;
      err = 1'b1;
      state_d = S_IDLE;
    end else if (en) begin
      valid_d = 1'b1;
      idx_d = idx;
      phase_d = 8'b1 << idx;
      ref_d = idx;
      state_d = S_LOCK;
      // only a locked 7->0 advance completes a revolution
      if (state_q == S_LOCK && idx == ref_q + 3'd1) begin
        tick_d = idx == 3'd0;
        rev_d = rev_q + REV_W'(tick_d);
      end else if (state_q == S_LOCK && idx != ref_q) begin
        seq_err_d = SEQ;
        err = SEQ;
      end
    end
    fault_d = err | (fault_q & ~fault_clr);
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      ref_q <= 3'd0;
      phase_q <= 8'd0;
      idx_q <= 3'd0;
      valid_q <= 1'b0;
      illegal_q <= 1'b0;
      seq_err_q <= 1'b0;
      fault_q <= 1'b0;
      rev_q <= '0;
      tick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q <= ref_d;
      phase_q <= phase_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
      illegal_q <= illegal_d;
      seq_err_q <= seq_err_d;
      fault_q <= fault_d;
      rev_q <= rev_d;
      tick_q <= tick_d;
    end
  end
  assign phase = phase_q;
  assign phase_idx = idx_q;
  assign valid = valid_q;
  assign illegal = illegal_q;
  assign seq_err = seq_err_q;
  assign fault = fault_q;
  assign rev_cnt = rev_q;
  assign rev_tick = tick_q;
endmodule

// File: tb/tb_jrc_phase_decoder.sv
// tb_jrc_phase_decoder: scoreboard bench comparing the decoder against a lookup-table model each cycle.
module tb_jrc_phase_decoder;
  logic clk = 1'b0, clr = 1'b0, qa = 1'b0, qb = 1'b0, qc = 1'b0, qd = 1'b0, en = 1'b0, fault_clr = 1'b0;
  logic [7:0] phase, rev_cnt;
  logic [2:0] phase_idx;
  logic valid, illegal, seq_err, fault, rev_tick;
  int checks = 0, errors = 0;
  logic [23:0] sb[$];
  logic [3:0] codes [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
  logic [7:0] m_ph = 0, m_rev = 0;
  logic [2:0] m_idx = 0;
  logic m_v = 0, m_f = 0, m_lock = 0;
  int m_ref = 0;
`ifdef JRC_PHASE_DECODER_SEQCHK_EN
  localparam logic SEQ = 1'b1;
`else
  localparam logic SEQ = 1'b0;
`endif

  jrc_phase_decoder #(.REV_W(8)) dut (
    .clk(clk), .clr(clr), .qa(qa), .qb(qb), .qc(qc), .qd(qd), .en(en), .fault_clr(fault_clr),
    .phase(phase), .phase_idx(phase_idx), .valid(valid), .illegal(illegal), .seq_err(seq_err),
    .fault(fault), .rev_cnt(rev_cnt), .rev_tick(rev_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // expected {phase,idx,valid,illegal,seq_err,fault,rev_cnt,rev_tick}
  task automatic step(input string tag, input logic [3:0] c, input logic e, input logic fc, input logic r);
    int k;
    logic ill, se, tk, er;
    {qa, qb, qc, qd} = c;
    en = e;
    fault_clr = fc;
    clr = r;
    k = -1;
    for (int i = 0; i < 8; i++) if (codes[i] == c) k = i;
    ill = 0; se = 0; tk = 0; er = 0;
    if (r) begin
      m_ph = 0; m_idx = 0; m_v = 0; m_f = 0; m_rev = 0; m_lock = 0; m_ref = 0;
    end else begin
      if (e && k < 0) begin
        m_v = 0; m_ph = 0; ill = 1; er = 1; m_lock = 0;
      end else if (e) begin
        m_v = 1; m_idx = 3'(k); m_ph = 8'(1 << k);
        if (m_lock && k == (m_ref + 1) % 8) begin
          if (k == 0) begin m_rev++; tk = 1; end
        end else if (m_lock && k != m_ref) begin
          se = SEQ; er = SEQ;
        end
        m_lock = 1; m_ref = k;
      end
      m_f = er ? 1'b1 : fc ? 1'b0 : m_f;
    end
    sb.push_back({m_ph, m_idx, m_v, ill, se, m_f, m_rev, tk});
    @(posedge clk);
    #1;
    chk(tag, {phase, phase_idx, valid, illegal, seq_err, fault, rev_cnt, rev_tick}, sb.pop_front());
  endtask

  initial begin
    step("reset", 4'b0000, 1, 1, 1);
    chk("reset_rev", rev_cnt, 0);
    for (int i = 0; i < 9; i++) step("fullseq", codes[i % 8], 1, 0, 0);
    chk("fullseq_rev", rev_cnt, 1);
    chk("fullseq_idx", phase_idx, 0);
    step("clr2", 4'b0000, 0, 0, 1);
    step("lock1100", 4'b1100, 1, 0, 0);
    step("jump1111", 4'b1111, 1, 0, 0);
    chk("jump_seq", seq_err, SEQ);
    chk("jump_fault", fault, SEQ);
    chk("jump_idx", phase_idx, 4);
    step("after_jump", 4'b1111, 1, 0, 0);
    chk("seq_pulse", seq_err, 0);
    step("ill1010", 4'b1010, 1, 0, 0);
    chk("ill_flags", {illegal, valid, phase, fault}, {1'b1, 1'b0, 8'd0, 1'b1});
    step("relock0000", 4'b0000, 1, 0, 0);
    chk("relock_tick", rev_tick, 0);
    step("ill_fclr", 4'b0101, 1, 1, 0);
    chk("ill_fclr_fault", fault, 1);
    step("relock", 4'b0000, 1, 0, 0);
    step("fclr", 4'b0000, 1, 1, 0);
    chk("fclr_fault", fault, 0);
    step("en0_a", 4'b1001, 0, 0, 0);
    step("en0_b", 4'b1000, 0, 0, 0);
    step("clr3", 4'b0000, 1, 0, 1);
    step("rev_start", 4'b0000, 1, 0, 0);
    for (int r = 0; r < 256; r++)
      for (int i = 1; i <= 8; i++) step("revs", codes[i % 8], 1, 0, 0);
    chk("wrap", {rev_cnt, rev_tick}, {8'd0, 1'b1});
    step("clr4", 4'b0000, 0, 0, 1);
    for (int i = 0; i <= 5; i++) step("to5", codes[i], 1, 0, 0);
    step("clr_mid", 4'b0011, 1, 1, 1);
    chk("clr_mid_out", {phase, phase_idx, valid, fault, rev_cnt}, 0);
    step("ill0110", 4'b0110, 1, 0, 0);
    chk("ill0110", illegal, 1);
    step("after_clr0", 4'b0000, 1, 0, 0);
    chk("after_clr_tick", rev_tick, 0);
    for (int n = 0; n < 300; n++) begin
      logic [3:0] c;
      c = ($urandom_range(0, 5) == 0) ? 4'($urandom) : codes[$urandom_range(0, 7)];
      step("rand", c, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
